sample_index_sequencer: RTL and testbench
=========================================

Name: sample_index_sequencer

Overview:
- Parametrised successor to the interpolation sample-count adder.
- Generates the sequence of sample indices the interpolation datapath processes: 0, step, 2·step, … up to a programmable limit.
- Supports single-pass and wrap (modulo) modes, with a valid/ready handshake toward the filter datapath and start/done/abort control from the top-level controller.
- Sits between the interpolation control FSM and the sample fetch/filter stage.

Parameters:
- IDX_W, 4, width of sample index and of cfg_limit.
- STEP_W, 4, width of cfg_step; must satisfy STEP_W <= IDX_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
- abort  in  1  terminate the current sequence.
- cfg_limit  in  IDX_W  highest legal index; latched on accepted start.
- cfg_step  in  STEP_W  index increment; latched on accepted start.
- cfg_wrap  in  1  0 = single pass, 1 = wrap modulo (limit+1); latched on accepted start.
- idx  out  IDX_W  current sample index.
- idx_valid  out  1  idx is valid.
- idx_ready  in  1  consumer accepts idx.
- last  out  1  qualifies idx: final index of the pass (single mode) or index after which wrap occurs (wrap mode).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of a single-pass sequence.

Behaviour:
- Reset: state=IDLE; idx=0, idx_valid=0, last=0, busy=0, done=0; latched config cleared to 0. Reset mid-sequence discards it, with no done pulse.
- FSM states: IDLE, RUN, DONE; registered state and outputs.
- IDLE:
  - start=1 → latch config; idx<=0, idx_valid<=1, busy<=1; go to RUN.
  - The first index is visible the cycle after start (latency 1).
  - start=0 → remain in IDLE.
- Effective step: step_e = max(cfg_step, 1), then clamped to limit+1. A step of 0 behaves as 1.
- Arithmetic: nxt = idx + step_e, computed at IDX_W+1 bits, so there is no overflow at limit = 2^IDX_W-1.
- RUN, handshake (idx_valid && idx_ready):
  - Single mode, nxt <= limit → idx<=nxt.
  - Single mode, nxt > limit → idx_valid<=0, busy<=0, done<=1; go to DONE.
  - Wrap mode, nxt <= limit → idx<=nxt.
  - Wrap mode, nxt > limit → idx<=nxt-(limit+1); stay in RUN.
- RUN, no handshake: idx, idx_valid and last hold stable. Backpressure may last indefinitely.
- last (combinational from registered idx and latched config) = idx_valid && (idx + step_e > limit).
- abort in RUN (takes priority over a handshake in the same cycle):
  - Next cycle: IDLE, idx_valid=0, busy=0, idx=0.
  - No done pulse. The index offered in the abort cycle counts as not consumed.
- abort in IDLE or DONE: ignored.
- DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- start while in RUN: ignored; config changes in RUN have no effect.
- Wrap mode never asserts done; it ends only via abort or reset.
- limit=0: single mode issues only index 0, with last=1.

Decomposition:
- Shared interpolation package holds:
  - the FSM state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2);
  - default IDX_W/STEP_W constants, reused by the fetch stage.
- One natural sub-module: idx_step_adder, a combinational, parametrised IDX_W-bit adder.
  - Inputs: idx, step_e, limit.
  - Outputs: the wrapped/next index and the overflow flag used for last and the transitions.
  - It generalises the existing 4-bit count adder.

Test Plan:
- Single pass, limit=9, step=2, idx_ready=1: start → idx 0,2,4,6,8 on consecutive cycles; last only with 8; done pulse one cycle after 8 is accepted; busy low at the same time.
- Backpressure: limit=3, step=1, idx_ready low for 3 cycles at idx=1 → idx stays 1 with valid held; resumes 2,3; done once.
- Wrap, limit=5, step=4: idx 0,4,2,0,4… with last on 4 and 2; no done; abort after 6 handshakes → idle next cycle, idx_valid=0, no done.
- Edge widths, IDX_W=4, limit=15, step=1 → 0..15 then done, with no overflow to 0. Step=0, limit=2 → 0,1,2.
- Reset and ignored inputs: rst_n asserted mid-RUN → all outputs 0 asynchronously. After release, start with limit=0 → single idx 0 with last=1, then done. A start issued during RUN is ignored.

Source files
------------

// File: rtl/sample_index_sequencer_pkg.sv
// Shared interpolation definitions: sequencer state encoding and default widths
// that the fetch stage reuses.
package sample_index_sequencer_pkg;

  localparam int DEF_IDX_W  = 4;
  localparam int DEF_STEP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sample_index_sequencer_idx_step_adder.sv
// Combinational index advance: idx + step_e at IDX_W+1 bits, with modulo (limit+1)
// fold-back. Assumes idx <= limit and step_e <= limit+1, so the folded value
// always fits in IDX_W bits.
module idx_step_adder
  import sample_index_sequencer_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W:0]   step_e,
  input  logic [IDX_W-1:0] limit,
  output logic [IDX_W-1:0] nxt_idx,
  output logic             over
);

  logic [IDX_W:0] sum;

  // Wide sum; the low bits minus (limit+1) are exact modulo 2^IDX_W when over is set.
  always_comb begin
    sum     = {1'b0, idx} + step_e;
    over    = (sum > {1'b0, limit});
    nxt_idx = over ? (sum[IDX_W-1:0] - limit - IDX_W'(1)) : sum[IDX_W-1:0];
  end

endmodule

// File: rtl/sample_index_sequencer.sv
// Sample index sequencer: issues 0, step, 2*step, ... up to a latched limit,
// single-pass or wrapping, over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for start; outputs quiet
// RUN     | offering idx with idx_valid, advancing on each handshake
// DONE    | one-cycle done pulse after a single pass completes
module sample_index_sequencer
  import sample_index_sequencer_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  cfg_limit,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              cfg_wrap,
  output logic [IDX_W-1:0]  idx,
  output logic              idx_valid,
  input  logic              idx_ready,
  output logic              last,
  output logic              busy,
  output logic              done
);

  state_t state, state_n;

  logic [IDX_W-1:0]  limit_q, limit_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic              wrap_q, wrap_n;
  logic [IDX_W-1:0]  idx_n;
  logic              idx_valid_n, busy_n, done_n;

  logic [IDX_W:0]    step_raw, limit_p1, step_e;
  logic [IDX_W-1:0]  adv_idx;
  logic              over;

  // Effective step: zero behaves as one, and never exceeds limit+1.
  always_comb begin
    step_raw = (IDX_W+1)'(step_q);
    limit_p1 = (IDX_W+1)'(limit_q) + (IDX_W+1)'(1);
    step_e   = (step_raw == '0) ? (IDX_W+1)'(1) : step_raw;
    if (step_e > limit_p1) begin
      step_e = limit_p1;
    end
  end

  idx_step_adder #(
    .IDX_W (IDX_W)
  ) u_adder (
    .idx     (idx),
    .step_e  (step_e),
    .limit   (limit_q),
    .nxt_idx (adv_idx),
    .over    (over)
  );

  assign last = idx_valid && over;

  // State, outputs and latched configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      idx_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      limit_q   <= '0;
      step_q    <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      idx_valid <= idx_valid_n;
      busy      <= busy_n;
      done      <= done_n;
      limit_q   <= limit_n;
      step_q    <= step_n;
      wrap_q    <= wrap_n;
    end
  end

  // Next-state and next-output decode; abort outranks a same-cycle handshake.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    idx_valid_n = idx_valid;
    busy_n      = busy;
    done_n      = 1'b0;
    limit_n     = limit_q;
    step_n      = step_q;
    wrap_n      = wrap_q;

    case (state)
      ST_IDLE: begin
        if (start) begin
          limit_n     = cfg_limit;
          step_n      = cfg_step;
          wrap_n      = cfg_wrap;
          idx_n       = '0;
          idx_valid_n = 1'b1;
          busy_n      = 1'b1;
          state_n     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          idx_n       = '0;
          idx_valid_n = 1'b0;
          busy_n      = 1'b0;
          state_n     = ST_IDLE;
        end else if (idx_valid && idx_ready) begin
          if (!over || wrap_q) begin
            idx_n = adv_idx;
          end else begin
            idx_valid_n = 1'b0;
            busy_n      = 1'b0;
            done_n      = 1'b1;
            state_n     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        idx_n       = '0;
        idx_valid_n = 1'b0;
        busy_n      = 1'b0;
        state_n     = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sample_index_sequencer.sv
// Scoreboard bench: each accepted start pushes the expected index stream into a
// queue; a negedge monitor compares every offered index and pops on handshake.
module tb_sample_index_sequencer;

  localparam int IDX_W  = 4;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort, cfg_wrap, idx_ready;
  logic [IDX_W-1:0]  cfg_limit;
  logic [STEP_W-1:0] cfg_step;
  logic [IDX_W-1:0]  idx;
  logic              idx_valid, last, busy, done;

  always #5 clk = ~clk;

  sample_index_sequencer #(.IDX_W(IDX_W), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_limit (cfg_limit),
    .cfg_step  (cfg_step),
    .cfg_wrap  (cfg_wrap),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int v;
    bit l;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  int stall_cnt = 0;
  int ready_mode = 0;
  bit exp_done_next = 1'b0;
  bit done_seen = 1'b0;
  bit model_wrap = 1'b0;
  bit prev_stall = 1'b0;
  logic [IDX_W-1:0] prev_idx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the index stream is k*step_e for single pass, (k*step_e) mod (limit+1) for wrap.
  task automatic model_start(input int lim, input int stp, input bit wrap);
    int se;
    se = (stp == 0) ? 1 : stp;
    if (se > lim + 1) se = lim + 1;
    q.delete();
    model_wrap = wrap;
    if (!wrap) begin
      for (int v = 0; v <= lim; v += se) q.push_back('{v, (v + se > lim)});
    end else begin
      for (int k = 0; k < 64; k++) begin
        int v;
        v = (k * se) % (lim + 1);
        q.push_back('{v, (v + se > lim)});
      end
    end
  endtask

  function automatic logic next_ready();
    case (ready_mode)
      0: return 1'b1;
      1: return ($urandom_range(0, 3) != 0);
      default: begin
        if (idx_valid && idx == 1 && stall_cnt < 3) begin
          stall_cnt++;
          return 1'b0;
        end
        return 1'b1;
      end
    endcase
  endfunction

  // Monitor: compare the offered index with the queue head, pop on handshake,
  // and predict the done pulse one cycle after the final single-pass handshake.
  always @(negedge clk) begin
    exp_t e;
    bit hs, nd;
    if (rst_n) begin
      check("done_pulse", done, exp_done_next);
      if (exp_done_next) begin
        check("busy_at_done", busy, 0);
        check("valid_at_done", idx_valid, 0);
      end
      if (done) done_seen = 1'b1;
      if (prev_stall) begin
        check("hold_idx", idx, prev_idx);
        check("hold_valid", idx_valid, 1);
      end
      hs = idx_valid && idx_ready && !abort;
      nd = 1'b0;
      if (idx_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_index: got idx %0d, expected no valid index", idx);
        end else begin
          e = q[0];
          check("idx", idx, e.v);
          check("last", last, e.l);
          if (hs) begin
            void'(q.pop_front());
            hs_count++;
            if (e.l && !model_wrap) nd = 1'b1;
          end
        end
      end else begin
        check("last_idle", last, 0);
      end
      exp_done_next = nd;
      prev_stall = idx_valid && !idx_ready && !abort;
      prev_idx = idx;
    end
  end

  task automatic run_seq(input int lim, input int stp, input bit wrap, input int rmode,
                         input int n_abort, input bit stray);
    int cycles;
    @(posedge clk); #1;
    cfg_limit = lim[IDX_W-1:0];
    cfg_step = stp[STEP_W-1:0];
    cfg_wrap = wrap;
    start = 1'b1;
    model_start(lim, stp, wrap);
    hs_count = 0;
    done_seen = 1'b0;
    stall_cnt = 0;
    ready_mode = rmode;
    @(posedge clk); #1;
    start = 1'b0;
    idx_ready = next_ready();
    cfg_limit = $urandom;
    cfg_step = $urandom;
    cfg_wrap = $urandom;
    @(negedge clk);
    check("first_valid", idx_valid, 1);
    check("first_idx", idx, 0);
    check("busy_run", busy, 1);
    cycles = 0;
    forever begin
      @(posedge clk); #1;
      cycles++;
      if (!wrap && done_seen) begin
        start = 1'b0;
        check("queue_drained", q.size(), 0);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", idx_valid, 0);
        break;
      end
      if (wrap && hs_count >= n_abort) begin
        abort = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        q.delete();
        @(negedge clk);
        check("abort_valid", idx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_idx", idx, 0);
        break;
      end
      if (cycles > 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL seq_timeout: limit %0d step %0d wrap %0d, %0d handshakes", lim, stp, wrap, hs_count);
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        q.delete();
        break;
      end
      idx_ready = next_ready();
      start = stray && ($urandom_range(0, 7) == 0);
      cfg_limit = $urandom;
      cfg_step = $urandom;
      cfg_wrap = $urandom;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_limit = '0;
    cfg_step = '0;
    cfg_wrap = 1'b0;
    idx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_idx", idx, 0);
    check("rst_valid", idx_valid, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_seq(9, 2, 0, 0, 0, 0);
    run_seq(3, 1, 0, 2, 0, 0);
    run_seq(5, 4, 1, 0, 6, 0);
    run_seq(15, 1, 0, 0, 0, 1);
    run_seq(2, 0, 0, 1, 0, 0);

    // abort while idle must not disturb anything
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", busy, 0);
    check("abort_idle_valid", idx_valid, 0);

    // asynchronous reset in the middle of a run
    @(posedge clk); #1;
    cfg_limit = 4'd9;
    cfg_step = 4'd1;
    cfg_wrap = 1'b0;
    start = 1'b1;
    model_start(9, 1, 0);
    ready_mode = 0;
    idx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_idx", idx, 0);
    check("arst_valid", idx_valid, 0);
    check("arst_last", last, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    q.delete();
    exp_done_next = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_seq(0, 5, 0, 0, 0, 1);

    repeat (12) begin
      bit w;
      w = $urandom_range(0, 1);
      run_seq($urandom_range(0, 15), $urandom_range(0, 15), w, 1, $urandom_range(1, 30), 1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
